// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and the word-wide data memory.
// Handles sub-word load extraction and byte/halfword stores via read-modify-write.
module mem_access_unit #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [5:0]           req_opcode,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [5:0]           opcode,
  output logic [WORD_SIZE-1:0] Address,
  output logic [WORD_SIZE-1:0] WriteData,
  input  logic [WORD_SIZE-1:0] ReadData
);

  localparam int unsigned W = WORD_SIZE;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     addr_lo_q, addr_lo_d;
  logic [15:0]    wdata_lo_q, wdata_lo_d;
  logic [5:0]     opcode_d;
  logic [W-1:0]   address_d;
  logic [W-1:0]   write_data_d;
  logic [W-1:0]   rdata_d;
  logic           err_d;
  logic           req_ready_d;
  logic           resp_valid_d;
  logic           mem_read_d;
  logic           mem_write_d;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_supported = 1'b1;
      default:                                                   is_supported = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_misaligned = lo[0];
      OP_LW, OP_SW:         is_misaligned = |lo;
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  // Little-endian lane extraction with sign/zero extension.
  function automatic logic [W-1:0] load_lane(input logic [5:0] op, input logic [1:0] lo,
                                             input logic [W-1:0] word);
    logic [W-1:0] byte_sh;
    logic [W-1:0] half_sh;
    logic [7:0]   b;
    logic [15:0]  h;
    byte_sh = word >> {lo, 3'b000};
    half_sh = word >> {lo[1], 4'b0000};
    b = byte_sh[7:0];
    h = half_sh[15:0];
    case (op)
      OP_LB:   load_lane = {{(W-8){b[7]}}, b};
      OP_LBU:  load_lane = W'(b);
      OP_LH:   load_lane = {{(W-16){h[15]}}, h};
      OP_LHU:  load_lane = W'(h);
      default: load_lane = word;
    endcase
  endfunction

  // Replace the addressed byte/halfword of the read word with store data.
  function automatic logic [W-1:0] merge_lane(input logic [5:0] op, input logic [1:0] lo,
                                              input logic [W-1:0] word, input logic [15:0] wd);
    logic [4:0] sh_b;
    logic [4:0] sh_h;
    sh_b = {lo, 3'b000};
    sh_h = {lo[1], 4'b0000};
    if (op == OP_SB)
      merge_lane = (word & ~(W'(8'hFF) << sh_b)) | (W'(wd[7:0]) << sh_b);
    else
      merge_lane = (word & ~(W'(16'hFFFF) << sh_h)) | (W'(wd) << sh_h);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_lo_q  <= '0;
      wdata_lo_q <= '0;
      opcode     <= '0;
      Address    <= '0;
      WriteData  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      wdata_lo_q <= wdata_lo_d;
      opcode     <= opcode_d;
      Address    <= address_d;
      WriteData  <= write_data_d;
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      MemRead    <= mem_read_d;
      MemWrite   <= mem_write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_lo_d    = addr_lo_q;
    wdata_lo_d   = wdata_lo_q;
    opcode_d     = opcode;
    address_d    = Address;
    write_data_d = WriteData;
    rdata_d      = resp_rdata;
    err_d        = resp_err;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          opcode_d   = req_opcode;
          address_d  = {2'b00, req_addr[W-1:2]};
          addr_lo_d  = req_addr[1:0];
          wdata_lo_d = req_wdata[15:0];
          rdata_d    = '0;
          err_d      = 1'b0;
          if (!is_supported(req_opcode) || is_misaligned(req_opcode, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_opcode == OP_SW) begin
            write_data_d = req_wdata;
            state_d      = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        // ReadData is only valid in this cycle.
        if (is_load(opcode)) begin
          rdata_d = load_lane(opcode, addr_lo_q, ReadData);
          state_d = RESP;
        end else begin
          write_data_d = merge_lane(opcode, addr_lo_q, ReadData, wdata_lo_q);
          state_d      = WR;
        end
      end
      WR: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags and strobes are registered copies of the next state.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_read_d   = (state_d == RD);
    mem_write_d  = (state_d == WR);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the pipeline MEM stage and the data memory `Mem`. It accepts one load/store request at a time over a valid/ready handshake. It drives `Mem`'s word-wide `MemRead`/`MemWrite` port and performs sub-word extraction for byte/halfword loads. Byte/halfword stores are done as read-modify-write, and the result or an error is returned over a valid/ready response channel.

## Interface
- `WORD_SIZE`, 32: data and address width. Byte-lane logic is defined for 32 only.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request. High only in IDLE.
- `req_opcode` in 6: MIPS opcode: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
- `req_addr` in WORD_SIZE: byte address.
- `req_wdata` in WORD_SIZE: store data, right-aligned for sb/sh.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out WORD_SIZE: load result, sign- or zero-extended. 0 for stores and errors.
- `resp_err` out 1: misaligned access or unsupported opcode.
- `MemRead` out 1: read strobe to `Mem`.
- `MemWrite` out 1: write strobe to `Mem`.
- `opcode` out 6: latched request opcode, forwarded to `Mem`.
- `Address` out WORD_SIZE: word index, equal to `{2'b00, addr[31:2]}`.
- `WriteData` out WORD_SIZE: full word to write.
- `ReadData` in WORD_SIZE: `Mem` output, registered by `Mem` on the edge where `MemRead` is sampled. It is valid only during the following cycle and is zero otherwise.

## Operation
- States: IDLE, RD, CAP, WR, RESP.
  - `MemRead` = (state==RD).
  - `MemWrite` = (state==WR).
  - Both strobes are decoded from the state register and are never high together.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, latch opcode, address and wdata, then branch:
  - Misaligned access (lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0) → RESP with err=1. No memory strobe is issued.
  - Unsupported opcode → RESP with err=1. No memory strobe is issued.
  - sw → WR with `WriteData`=wdata.
  - Any load, sb or sh → RD.
- RD: one cycle with `MemRead`=1, then → CAP.
- CAP: `ReadData` is valid in this cycle.
  - Loads: extract the lane, register it into `resp_rdata`, → RESP.
  - sb/sh: register the merged word into `WriteData`, → WR.
- Lane selection is little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; halfword h = bits [16h+15:16h], h = addr[1].
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- Merge:
  - sb replaces byte k of `ReadData` with wdata[7:0].
  - sh replaces halfword h of `ReadData` with wdata[15:0].
  - All other lanes keep the `ReadData` value.
- WR: one cycle with `MemWrite`=1, then → RESP. `resp_rdata`=0.
- RESP: `resp_valid`=1, with `resp_rdata`/`resp_err` held stable until `resp_ready`. On the handshake → IDLE. No new request is accepted in the same cycle.
- `Address` and `opcode` are registered at accept and held stable through RD/CAP/WR.

## Timing
- Reset (async, immediate) sets the following. The reset value of `WriteData` is also 0.
  - state=IDLE
  - `req_ready`=1
  - `resp_valid`=0
  - `resp_err`=0
  - `resp_rdata`=0
  - `MemRead`=0
  - `MemWrite`=0
  - `Address`=0
  - `opcode`=0
- Latency is measured from the accept edge to the first cycle with `resp_valid`=1:
  - Error: 1 cycle.
  - sw: 2 cycles.
  - Loads: 3 cycles.
  - sb/sh: 4 cycles.
- Throughput is at most one request per (latency + 1) cycles when `resp_ready` is held high.
- `resp_ready` held low stalls indefinitely in RESP. No memory strobe is issued while stalled.
- Reset asserted in RD or CAP during sb/sh: the WR strobe is never issued and memory is unchanged.
- Reset asserted in WR: `MemWrite` drops asynchronously. Whether the write lands depends on whether `rst` rose before the clock edge.
- `req_valid` while not IDLE is ignored. The requester must hold it until `req_ready`.

## Test plan
- Store word then load: sw addr 0x10 data 0xDEADBEEF, then lw 0x10. Required: `Address`=4 with `MemWrite`=1 for exactly one cycle; lw `resp_rdata`=0xDEADBEEF, err=0, 3 cycles after accept.
- Byte and halfword loads from word 0x80F17F01 at addr 0x20:
  - lb 0x23 → 0xFFFFFF80
  - lbu 0x23 → 0x00000080
  - lb 0x21 → 0x0000007F
  - lh 0x22 → 0xFFFF80F1
  - lhu 0x20 → 0x00007F01
- Read-modify-write:
  - Word 0x11223344 at 0x30, sb 0x31 data 0xAB → `WriteData`=0x1122AB44; a following lw returns 0x1122AB44.
  - Then sh 0x32 data 0xCDEF → word 0xCDEFAB44.
  - Sequence for each store is RD, CAP, WR with one strobe each.
- Errors: lw 0x12, sh 0x05, opcode 0x00. Each gives `resp_err`=1, `resp_rdata`=0, response 1 cycle after accept, and `MemRead`/`MemWrite` never asserted.
- Backpressure: hold `resp_ready`=0 for 5 cycles after a load response. Required: `resp_valid` and data stable, `req_ready`=0, no strobes; the handshake then returns to IDLE one cycle later.
- Reset mid-operation: assert `rst` in CAP of sb 0x31 on word 0x11223344. Required: outputs reset immediately; a subsequent lw 0x30 returns 0x11223344.
